lbdr_dr_fsm: RTL and testbench

//  Packet-level LBDR routing unit for one router input port, successor to the minimal LBDR.
//  - Parametrised mesh coordinates.
//  - Adds a deroute fallback when no minimal port is usable.
//  - Adds runtime-writable routing/connectivity config.
//  - Adds a header/tail FSM that holds the one-hot port request for the whole packet.

---
 rtl/lbdr_dr_fsm_pkg.sv | 37 +++
 rtl/lbdr_route_comb.sv | 59 +++++
 rtl/lbdr_dr_fsm.sv | 124 ++++++++++++
 tb/tb_lbdr_dr_fsm.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/lbdr_dr_fsm_pkg.sv
// Shared encodings for the LBDR deroute router input unit: flit types, deroute ports,
// FSM states, the one-hot port request and the routing config word.
package lbdr_dr_fsm_pkg;

  localparam logic [2:0] FLIT_HEADER  = 3'b001;
  localparam logic [2:0] FLIT_PAYLOAD = 3'b010;
  localparam logic [2:0] FLIT_TAIL    = 3'b100;

  // Deroute port codes double as the index into the connectivity bits {Cs,Cw,Ce,Cn}.
  localparam logic [1:0] DR_N = 2'b00;
  localparam logic [1:0] DR_E = 2'b01;
  localparam logic [1:0] DR_W = 2'b10;
  localparam logic [1:0] DR_S = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROUTED = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  typedef struct packed {
    logic n;
    logic e;
    logic w;
    logic s;
    logic l;
  } port_req_t;

  // rxy = {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}, cx = {Cs,Cw,Ce,Cn}
  typedef struct packed {
    logic [7:0] rxy;
    logic [3:0] cx;
    logic [1:0] dr;
    logic       dr_en;
  } route_cfg_t;

endpackage

// File: rtl/lbdr_route_comb.sv
// Purpose: LBDR minimal-port compute with deroute fallback for one header.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module lbdr_route_comb
  import lbdr_dr_fsm_pkg::*;
#(
  parameter int X_W = 2,
  parameter int Y_W = 2
) (
  input  logic [X_W+Y_W-1:0] cur_addr,
  input  logic [X_W+Y_W-1:0] dst_addr,
  input  route_cfg_t         cfg,
  output port_req_t          req,
  output logic               derouted,
  output logic               route_err
);

  logic [X_W-1:0] cx_c, dx_c;
  logic [Y_W-1:0] cy_c, dy_c;
  logic           n_p, s_p, e_p, w_p;
  port_req_t      min_req;

  assign cx_c = cur_addr[X_W-1:0];
  assign cy_c = cur_addr[X_W+Y_W-1:X_W];
  assign dx_c = dst_addr[X_W-1:0];
  assign dy_c = dst_addr[X_W+Y_W-1:X_W];

  assign n_p = dy_c < cy_c;
  assign s_p = dy_c > cy_c;
  assign e_p = dx_c > cx_c;
  assign w_p = dx_c < cx_c;

  assign min_req.n = cfg.cx[0] & n_p & ((!e_p & !w_p) | (e_p & cfg.rxy[0]) | (w_p & cfg.rxy[1]));
  assign min_req.e = cfg.cx[1] & e_p & ((!n_p & !s_p) | (n_p & cfg.rxy[2]) | (s_p & cfg.rxy[3]));
  assign min_req.w = cfg.cx[2] & w_p & ((!n_p & !s_p) | (n_p & cfg.rxy[4]) | (s_p & cfg.rxy[5]));
  assign min_req.s = cfg.cx[3] & s_p & ((!e_p & !w_p) | (e_p & cfg.rxy[6]) | (w_p & cfg.rxy[7]));
  assign min_req.l = !(n_p | s_p | e_p | w_p);

  // An all-zero minimal request implies a non-local destination.
  always_comb begin
    req       = min_req;
    derouted  = 1'b0;
    route_err = 1'b0;
    if (min_req == '0) begin
      if (cfg.dr_en && cfg.cx[cfg.dr]) begin
        derouted = 1'b1;
        case (cfg.dr)
          DR_N: req.n = 1'b1;
          DR_E: req.e = 1'b1;
          DR_W: req.w = 1'b1;
          DR_S: req.s = 1'b1;
        endcase
      end else begin
        route_err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lbdr_dr_fsm.sv
// Purpose: per-input-port LBDR routing with deroute, runtime config and a packet-hold FSM.
// Latency: header at FIFO head -> registered one-hot port request one cycle later.
// Backpressure: flits advance only on allocator rd_en; the request is held until the tail pops.
module lbdr_dr_fsm
  import lbdr_dr_fsm_pkg::*;
#(
  parameter int                   X_W       = 2,
  parameter int                   Y_W       = 2,
  parameter logic [X_W+Y_W-1:0]   CUR_ADDR  = '0,
  parameter logic [7:0]           RXY_DEF   = 8'b00111100,
  parameter logic [3:0]           CX_DEF    = 4'b1111,
  parameter logic [1:0]           DR_DEF    = 2'b00,
  parameter logic                 DR_EN_DEF = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               empty,
  input  logic               rd_en,
  input  logic [2:0]         flit_id,
  input  logic [X_W+Y_W-1:0] dst_addr,
  input  logic               cfg_we,
  input  logic [X_W+Y_W-1:0] cfg_cur_addr,
  input  logic [7:0]         cfg_rxy,
  input  logic [3:0]         cfg_cx,
  input  logic [1:0]         cfg_dr,
  input  logic               cfg_dr_en,
  output logic               Nport,
  output logic               Eport,
  output logic               Wport,
  output logic               Sport,
  output logic               Lport,
  output logic               route_vld,
  output logic               derouted,
  output logic               route_err,
  output logic               busy
);

  state_t             state;
  logic [X_W+Y_W-1:0] cur_addr_q, pend_addr;
  route_cfg_t         cfg_q, pend_cfg, cfg_in;
  logic               pend_vld;
  port_req_t          req_q, req_c;
  logic               dr_c, err_c;
  logic               hdr_seen, tail_pop;

  assign cfg_in   = {cfg_rxy, cfg_cx, cfg_dr, cfg_dr_en};
  assign hdr_seen = !empty && (flit_id == FLIT_HEADER);
  assign tail_pop = !empty && rd_en && (flit_id == FLIT_TAIL);

  lbdr_route_comb #(.X_W(X_W), .Y_W(Y_W)) u_route (
    .cur_addr  (cur_addr_q),
    .dst_addr  (dst_addr),
    .cfg       (cfg_q),
    .req       (req_c),
    .derouted  (dr_c),
    .route_err (err_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cur_addr_q <= CUR_ADDR;
      cfg_q      <= {RXY_DEF, CX_DEF, DR_DEF, DR_EN_DEF};
      pend_vld   <= 1'b0;
      pend_addr  <= '0;
      pend_cfg   <= '0;
      req_q      <= '0;
      route_vld  <= 1'b0;
      derouted   <= 1'b0;
      route_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // The header in this cycle is routed with the config currently held.
          if (cfg_we) begin
            cur_addr_q <= cfg_cur_addr;
            cfg_q      <= cfg_in;
          end
          if (hdr_seen) begin
            req_q     <= req_c;
            route_vld <= !err_c;
            derouted  <= dr_c;
            route_err <= err_c;
            busy      <= 1'b1;
            state     <= err_c ? ST_DRAIN : ST_ROUTED;
          end
        end
        ST_ROUTED, ST_DRAIN: begin
          if (cfg_we) begin
            pend_vld  <= 1'b1;
            pend_addr <= cfg_cur_addr;
            pend_cfg  <= cfg_in;
          end
          if (tail_pop) begin
            state     <= ST_IDLE;
            req_q     <= '0;
            route_vld <= 1'b0;
            derouted  <= 1'b0;
            route_err <= 1'b0;
            busy      <= 1'b0;
            pend_vld  <= 1'b0;
            // A write landing on the tail edge is the newest, so it beats the pending slot.
            if (cfg_we) begin
              cur_addr_q <= cfg_cur_addr;
              cfg_q      <= cfg_in;
            end else if (pend_vld) begin
              cur_addr_q <= pend_addr;
              cfg_q      <= pend_cfg;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Nport = req_q.n;
  assign Eport = req_q.e;
  assign Wport = req_q.w;
  assign Sport = req_q.s;
  assign Lport = req_q.l;

endmodule

// File: tb/tb_lbdr_dr_fsm.sv
// Directed bench for lbdr_dr_fsm: hand-computed port requests and status flags per vector.
module tb_lbdr_dr_fsm;
  import lbdr_dr_fsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       empty, rd_en, cfg_we, cfg_dr_en;
  logic [2:0] flit_id;
  logic [3:0] dst_addr, cfg_cur_addr, cfg_cx;
  logic [7:0] cfg_rxy;
  logic [1:0] cfg_dr;
  logic       Nport, Eport, Wport, Sport, Lport, route_vld, derouted, route_err, busy;
  logic [4:0] ports;
  logic [3:0] flags;

  int checks   = 0;
  int failures = 0;

  localparam logic [7:0] RXY_XY = 8'b00111100;

  always #5 clk = ~clk;

  assign ports = {Nport, Eport, Wport, Sport, Lport};
  assign flags = {route_vld, derouted, route_err, busy};

  lbdr_dr_fsm dut (
    .clk(clk), .rst(rst), .empty(empty), .rd_en(rd_en), .flit_id(flit_id),
    .dst_addr(dst_addr), .cfg_we(cfg_we), .cfg_cur_addr(cfg_cur_addr),
    .cfg_rxy(cfg_rxy), .cfg_cx(cfg_cx), .cfg_dr(cfg_dr), .cfg_dr_en(cfg_dr_en),
    .Nport(Nport), .Eport(Eport), .Wport(Wport), .Sport(Sport), .Lport(Lport),
    .route_vld(route_vld), .derouted(derouted), .route_err(route_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] rxy, input logic [3:0] cx,
                           input logic [1:0] dr, input logic en);
    cfg_cur_addr = a; cfg_rxy = rxy; cfg_cx = cx; cfg_dr = dr; cfg_dr_en = en;
    cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  // One flit present and popped in the same cycle.
  task automatic push(input logic [2:0] f, input logic [3:0] d);
    empty = 1'b0; flit_id = f; dst_addr = d; rd_en = 1'b1;
    step();
    empty = 1'b1; rd_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; empty = 1'b1; rd_en = 1'b0; flit_id = FLIT_PAYLOAD; dst_addr = '0;
    cfg_we = 1'b0; cfg_cur_addr = '0; cfg_rxy = RXY_XY; cfg_cx = 4'b1111;
    cfg_dr = DR_N; cfg_dr_en = 1'b0;
    #22;
    chk("reset_ports", 8'(ports), 8'b0);
    chk("reset_flags", 8'(flags), 8'b0);
    rst = 1'b1;

    // 1: node (x1,y0) -> dst (x0,y2), Cn down: minimal west, held for the packet.
    cfg_write(4'b0001, RXY_XY, 4'b1110, DR_N, 1'b0);
    push(FLIT_HEADER, 4'b1000);
    chk("t1_hdr_ports", 8'(ports), 8'b00100);
    chk("t1_hdr_flags", 8'(flags), 8'b1001);
    for (int i = 0; i < 4; i++) begin
      push(FLIT_PAYLOAD, 4'(i));
      chk($sformatf("t1_pay%0d_ports", i), 8'(ports), 8'b00100);
    end
    push(FLIT_TAIL, 4'b0000);
    chk("t1_tail_ports", 8'(ports), 8'b0);
    chk("t1_tail_flags", 8'(flags), 8'b0);

    // 2: straight south, then local delivery.
    cfg_write(4'b0000, RXY_XY, 4'b1010, DR_N, 1'b0);
    push(FLIT_HEADER, 4'b1000);
    chk("t2_south_ports", 8'(ports), 8'b00010);
    push(FLIT_TAIL, 4'b0000);
    cfg_write(4'b1000, RXY_XY, 4'b1010, DR_N, 1'b0);
    push(FLIT_HEADER, 4'b1000);
    chk("t2_local_ports", 8'(ports), 8'b00001);
    chk("t2_local_flags", 8'(flags), 8'b1001);
    push(FLIT_TAIL, 4'b0000);

    // 3: east blocked, deroute south usable; then deroute east blocked -> drain.
    cfg_write(4'b0000, RXY_XY, 4'b1000, DR_S, 1'b1);
    push(FLIT_HEADER, 4'b0010);
    chk("t3_dr_ports", 8'(ports), 8'b00010);
    chk("t3_dr_flags", 8'(flags), 8'b1101);
    push(FLIT_TAIL, 4'b0000);
    cfg_write(4'b0000, RXY_XY, 4'b1000, DR_E, 1'b1);
    push(FLIT_HEADER, 4'b0010);
    chk("t3_err_ports", 8'(ports), 8'b0);
    chk("t3_err_flags", 8'(flags), 8'b0011);
    push(FLIT_PAYLOAD, 4'b0000);
    chk("t3_drain_flags", 8'(flags), 8'b0011);
    push(FLIT_TAIL, 4'b0000);
    chk("t3_exit_flags", 8'(flags), 8'b0);

    // 4: config writes mid-packet are deferred; last one wins at the tail.
    cfg_write(4'b0001, RXY_XY, 4'b1110, DR_N, 1'b0);
    push(FLIT_HEADER, 4'b1000);
    cfg_write(4'b0001, RXY_XY, 4'b1111, DR_N, 1'b0);
    chk("t4_wr1_ports", 8'(ports), 8'b00100);
    cfg_write(4'b0001, RXY_XY, 4'b0000, DR_N, 1'b0);
    push(FLIT_PAYLOAD, 4'b0000);
    chk("t4_wr2_ports", 8'(ports), 8'b00100);
    push(FLIT_TAIL, 4'b0000);
    chk("t4_tail_ports", 8'(ports), 8'b0);
    push(FLIT_HEADER, 4'b1000);
    chk("t4_newcfg_flags", 8'(flags), 8'b0011);
    chk("t4_newcfg_ports", 8'(ports), 8'b0);
    push(FLIT_TAIL, 4'b0000);

    // 5: head flit fields are ignored while the FIFO is empty.
    cfg_write(4'b0001, RXY_XY, 4'b1110, DR_N, 1'b0);
    empty = 1'b1; flit_id = FLIT_HEADER; dst_addr = 4'b1000;
    step();
    chk("t5_idle_empty_flags", 8'(flags), 8'b0);
    push(FLIT_HEADER, 4'b1000);
    empty = 1'b1; flit_id = FLIT_TAIL; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t5_tail_empty_flags", 8'(flags), 8'b1001);
    chk("t5_tail_empty_ports", 8'(ports), 8'b00100);

    // 6: async reset mid-packet, with a pending write that must be dropped.
    cfg_write(4'b0010, RXY_XY, 4'b0001, DR_N, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("t6_arst_ports", 8'(ports), 8'b0);
    chk("t6_arst_flags", 8'(flags), 8'b0);
    #2 rst = 1'b1;
    push(FLIT_HEADER, 4'b0000);
    chk("t6_default_cfg_ports", 8'(ports), 8'b00001);
    push(FLIT_TAIL, 4'b0000);
    chk("t6_end_flags", 8'(flags), 8'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
